// File: rtl/uart_pkg.sv
// Register map and sequencer state type shared by the UART top-level and its
// transmit sequencer, so both sides decode the same addresses.
package uart_pkg;

    localparam logic [1:0] BAUD_DATA = 2'd0;
    localparam logic [1:0] ENABLE    = 2'd1;
    localparam logic [1:0] TX_DATA   = 2'd2;
    localparam logic [1:0] RX_DATA   = 2'd3;

    typedef enum logic [2:0] {
        S_BAUD,
        S_EN,
        S_IDLE,
        S_LOAD,
        S_WAIT
    } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte-wide synchronous FIFO with a combinational head. Pushes while full and
// pops while empty are ignored.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_en;
    logic          pop_en;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_en && !pop_en) begin
                count_q <= count_q + 1'b1;
            end else if (!push_en && pop_en) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Register-bus master for the UART: programs baud/enable after reset, then
// writes buffered bytes to TX_DATA, each followed by a timed frame gap.
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter logic [7:0]  BAUD_DIV   = 8'd27,
    parameter int unsigned FRAME_BITS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] address,
    output logic [7:0] write_data,
    output logic       we,
    output logic       re,
    output logic       init_done,
    output logic       busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [15:0] GAP = 16'(FRAME_BITS * (32'(BAUD_DIV) + 32'd1));

    tx_state_e   state_q, state_d;
    logic [15:0] gap_q, gap_d;
    logic [1:0]  address_q, address_d;
    logic [7:0]  write_data_q, write_data_d;
    logic        we_q, we_d;
    logic        init_done_q, init_done_d;

    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;

    assign in_ready  = (fifo_count != FULL_COUNT);
    assign fifo_push = in_valid & ~fifo_full;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Each arm computes the bus outputs that become visible in the following cycle.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        we_d         = 1'b0;
        init_done_d  = init_done_q;
        fifo_pop     = 1'b0;

        case (state_q)
            S_BAUD: begin
                we_d         = 1'b1;
                address_d    = BAUD_DATA;
                write_data_d = BAUD_DIV;
                state_d      = S_EN;
            end
            S_EN: begin
                we_d         = 1'b1;
                address_d    = ENABLE;
                write_data_d = 8'h01;
                state_d      = S_IDLE;
            end
            S_IDLE: begin
                init_done_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    we_d         = 1'b1;
                    address_d    = TX_DATA;
                    write_data_d = fifo_dout;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                gap_d   = GAP - 16'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 16'd1;
                end else if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    we_d         = 1'b1;
                    address_d    = TX_DATA;
                    write_data_d = fifo_dout;
                    state_d      = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_BAUD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BAUD;
            gap_q        <= '0;
            address_q    <= '0;
            write_data_q <= '0;
            we_q         <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            we_q         <= we_d;
            init_done_q  <= init_done_d;
        end
    end

    assign address    = address_q;
    assign write_data = write_data_q;
    assign we         = we_q;
    assign re         = 1'b0;
    assign init_done  = init_done_q;
    assign busy       = !((state_q == S_IDLE) && fifo_empty);

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed and randomized stimulus for uart_tx_sequencer, checked every cycle against a
// schedule model: each accepted byte is written at max(accept+1, init end, previous+GAP+1).
module tb_uart_tx_sequencer;

    localparam int DEPTH      = 8;
    localparam int BAUD       = 3;
    localparam int FRAME_BITS = 10;
    localparam int GAP        = FRAME_BITS * (BAUD + 1);

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] address;
    logic [7:0] write_data;
    logic       we;
    logic       re;
    logic       init_done;
    logic       busy;

    uart_tx_sequencer #(
        .DEPTH      (DEPTH),
        .BAUD_DIV   (8'(BAUD)),
        .FRAME_BITS (FRAME_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .address    (address),
        .write_data (write_data),
        .we         (we),
        .re         (re),
        .init_done  (init_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: edge counter, last reset edge, and the write schedule since that reset.
    int         e      = 0;
    int         r_edge = 0;
    int         sq_edge[$];
    logic [7:0] sq_data[$];
    int         last_sched = 0;
    bit         have_sched = 0;
    logic [1:0] exp_addr   = 2'd0;
    logic [7:0] exp_data   = 8'd0;
    bit         exp_ready  = 1'b1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    task automatic check_cycle();
        bit         wr_tx = 1'b0;
        logic [7:0] tx    = 8'd0;
        int         cnt   = 0;
        bit         in_gap = 1'b0;
        bit         exp_we;
        bit         exp_busy;
        foreach (sq_edge[i]) begin
            if (sq_edge[i] > e) cnt++;
            if (sq_edge[i] == e) begin
                wr_tx = 1'b1;
                tx    = sq_data[i];
            end
            if (sq_edge[i] <= e && e <= sq_edge[i] + GAP) in_gap = 1'b1;
        end
        exp_we = wr_tx || (e == r_edge + 1) || (e == r_edge + 2);
        if (e == r_edge + 1) begin
            exp_addr = 2'd0;
            exp_data = 8'(BAUD);
        end else if (e == r_edge + 2) begin
            exp_addr = 2'd1;
            exp_data = 8'h01;
        end else if (wr_tx) begin
            exp_addr = 2'd2;
            exp_data = tx;
        end
        exp_ready = (cnt != DEPTH);
        exp_busy  = (e < r_edge + 2) || (cnt > 0) || in_gap;
        chk("we", 16'(we), 16'(exp_we));
        chk("address", 16'(address), 16'(exp_addr));
        chk("write_data", 16'(write_data), 16'(exp_data));
        chk("in_ready", 16'(in_ready), 16'(exp_ready));
        chk("busy", 16'(busy), 16'(exp_busy));
        chk("init_done", 16'(init_done), 16'(e >= r_edge + 3));
        chk("re", 16'(re), 16'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        e++;
        if (rst) begin
            r_edge     = e;
            have_sched = 1'b0;
            exp_addr   = 2'd0;
            exp_data   = 8'd0;
            sq_edge.delete();
            sq_data.delete();
        end else if (in_valid && exp_ready) begin
            int w;
            w = e + 1;
            if (w < r_edge + 3) w = r_edge + 3;
            if (have_sched && w < last_sched + GAP + 1) w = last_sched + GAP + 1;
            sq_edge.push_back(w);
            sq_data.push_back(in_data);
            last_sched = w;
            have_sched = 1'b1;
        end
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int got;
        int budget;
        int target;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset and init sequence
        tick();
        tick();
        rst = 1'b0;
        idle(6);

        // Single byte, then a full gap
        push_byte(8'hA5);
        idle(GAP + 6);

        // Back-to-back burst
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        idle(3 * (GAP + 1) + 6);

        // Overfill while the sequencer sits in its gap
        push_byte(8'h5A);
        idle(3);
        got    = 0;
        budget = 0;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        while (got < DEPTH + 1 && budget < 300) begin
            bit acc;
            acc = exp_ready;
            tick();
            if (acc) begin
                got++;
                in_data = 8'($urandom);
            end
            budget++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != DEPTH + 1) begin
            failures++;
            $error("FAIL fill_budget: accepted=%0d required=%0d", got, DEPTH + 1);
        end
        idle((DEPTH + 2) * (GAP + 1));

        // Push landing exactly on a pop edge with three bytes queued
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        push_byte(8'hC4);
        target = sq_edge[sq_edge.size() - 3];
        budget = 0;
        while (e < target - 1 && budget < 200) begin
            tick();
            budget++;
        end
        push_byte(8'hC5);
        idle(5 * (GAP + 1) + 6);

        // Reset in the middle of a gap with bytes still queued
        push_byte(8'hD1);
        push_byte(8'hD2);
        push_byte(8'hD3);
        idle(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(3 * (GAP + 1));
        push_byte(8'hE7);
        idle(GAP + 6);

        // Random traffic with occasional resets
        for (int i = 0; i < 900; i++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 8'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        idle((DEPTH + 2) * (GAP + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Register-bus master that sits directly upstream of the UART top-level and drives its register port. After reset it programs the baud divisor and the enable bit. It then buffers bytes arriving on a valid/ready stream in a small FIFO. Each byte is written to the TX data register and followed by a timed frame gap, because the UART exposes no TX-busy status.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; power of two, ≥2.
- `BAUD_DIV`, 8'd27: value written to the baud register at init.
- `FRAME_BITS`, 10: bit periods per UART frame (start + 8 data + stop).
- `GAP`, FRAME_BITS*(BAUD_DIV+1): wait cycles after each TX write; localparam, 16-bit.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 8: byte to transmit.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: FIFO can accept a byte. Transfer occurs on a clock edge where `in_valid` and `in_ready` are both 1.
- `address` out 2: UART register address.
- `write_data` out 8: UART register write data.
- `we` out 1: UART register write strobe, one cycle per write.
- `re` out 1: UART read strobe; constant 0.
- `init_done` out 1: baud and enable writes are complete.
- `busy` out 1: FIFO is non-empty or a write/gap is in progress.

## Operation
- Register map, shared with the UART: `BAUD_DATA`=0, `ENABLE`=1, `TX_DATA`=2, `RX_DATA`=3.
- FSM states: `S_BAUD`, `S_EN`, `S_IDLE`, `S_LOAD`, `S_WAIT`.
- `S_BAUD`: drive `we`=1, `address`=0, `write_data`=`BAUD_DIV`. Next state is `S_EN`.
- `S_EN`: drive `we`=1, `address`=1, `write_data`=8'h01. Next state is `S_IDLE`; `init_done` is set.
- `S_IDLE`: drive `we`=0. If the FIFO is non-empty, go to `S_LOAD` and pop the head on that edge.
- `S_LOAD`: drive `we`=1, `address`=2, `write_data`=popped byte. Load the gap counter with `GAP`-1. Next state is `S_WAIT`.
- `S_WAIT`: drive `we`=0 and decrement the counter each cycle.
  - When the counter is 0 and the FIFO is non-empty: pop and go directly to `S_LOAD`.
  - When the counter is 0 and the FIFO is empty: go to `S_IDLE`.
- All outputs are registered except `in_ready` and `busy`, which decode directly from registers.
- `in_ready` = (count != `DEPTH`). It has no combinational path from `in_valid`.
- Bytes are accepted during init; they are buffered and sent after `init_done`.
- Push and pop on the same edge leave the count unchanged and keep data order intact.
- When the FIFO is full, `in_ready` is 0 and `in_data` is ignored, even on an edge that pops.
- Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`. The count is log2(`DEPTH`)+1 bits.
- `address` and `write_data` hold their last values while `we`=0.

## Timing
- **Edge with `rst`=1:** state becomes `S_BAUD`. FIFO is flushed (count 0, pointers 0). All outputs reset: `address`=0, `write_data`=0, `we`=0, `init_done`=0, `busy`=1.
- **First cycle after `rst` falls:** baud write (`we`=1, `address`=0).
- **Second cycle:** enable write (`we`=1, `address`=1).
- **Third cycle onward:** `init_done`=1.
- **Latency, idle and empty:** a byte accepted at edge N produces `we`=1 with `address`=2 in the cycle after edge N+1.
- **Backlogged FIFO:** consecutive `TX_DATA` writes are exactly `GAP`+1 cycles apart.
- **Reset mid-operation** (any state, including `S_WAIT`): immediate return to the reset values above. Buffered bytes are discarded, and the init writes are repeated.
- **`busy`:** 0 only in `S_IDLE` with an empty FIFO.

## Structure
- Package `uart_pkg` holds:
  - register address constants `BAUD_DATA`, `ENABLE`, `TX_DATA`, `RX_DATA`, so this block and the UART top-level decode the same values;
  - the FSM state typedef.
- Sub-module `uart_byte_fifo`: synchronous FIFO with parameter `DEPTH`.
  - Ports: `push`/`pop`, `din`/`dout`, `full`/`empty`, `count`.
  - `dout` shows the head combinationally.
- The top of this block contains only the FSM and the gap counter.

## Test plan
- **Reset/init:** `BAUD_DIV`=3, release `rst`. Cycle 1: `we`=1, `address`=0, `write_data`=8'h03. Cycle 2: `we`=1, `address`=1, `write_data`=8'h01. `init_done`=1 from cycle 3. `we`=0 afterwards.
- **Single byte:** push 8'hA5 at edge N. `we`=1, `address`=2, `write_data`=8'hA5 one cycle after edge N+1. Then 40 cycles (`GAP`) with `we`=0. `busy` falls on the edge `S_WAIT` exits to `S_IDLE`.
- **Burst:** push 8'h11, 8'h22, 8'h33 back-to-back. Three `TX_DATA` writes in that order, spaced exactly 41 cycles apart.
- **Full:** hold `in_valid` with `DEPTH`+1 bytes during `S_WAIT`. `in_ready` drops after the 8th accept. The 9th byte is held and accepted only after the next pop. No byte is lost or duplicated.
- **Simultaneous push/pop:** push exactly on the pop edge with count 3. Count stays 3 and output order is preserved.
- **Reset mid-gap:** assert `rst` for one cycle in `S_WAIT` with 2 bytes queued. Buffered bytes are discarded. The init sequence repeats, and no `TX_DATA` write occurs until a new push.
